// File: rtl/tm_class_scheduler_if.sv
// Scheduler-side bundle: TM core controller handshake plus host result channel.
// master = scheduler, slave = core controller / host environment.
interface tm_class_scheduler_if #(
  parameter int SUM_W   = 12,
  parameter int CLASS_W = 4
);
  logic               core_stop;
  logic               core_rst;
  logic               core_done;
  logic [SUM_W-1:0]   class_sum;
  logic [CLASS_W-1:0] class_sel;
  logic               pred_valid;
  logic               pred_ready;
  logic [CLASS_W-1:0] pred_class;
  logic [SUM_W-1:0]   pred_sum;
  logic               pred_err;

  modport master (
    output core_stop, core_rst, class_sel, pred_valid, pred_class, pred_sum, pred_err,
    input  core_done, class_sum, pred_ready
  );
  modport slave (
    input  core_stop, core_rst, class_sel, pred_valid, pred_class, pred_sum, pred_err,
    output core_done, class_sum, pred_ready
  );
endinterface

// File: rtl/tm_class_scheduler.sv
// Sequences one inference over all class banks on the shared TM core, tracks the
// signed argmax and hands the winner to the host; a watchdog aborts a stuck class.
module tm_class_scheduler #(
  parameter int CLASSES = 10,
  parameter int SUM_W   = 12,
  parameter int TIMEOUT = 1000000,
  parameter int TMO_W   = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  tm_class_scheduler_if.master   bus
);
  localparam int CLASS_W = $clog2(CLASSES);
  localparam logic [CLASS_W-1:0] SEL_LAST = CLASS_W'(CLASSES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, CAPTURE, RELEASE, OUT} state_t;

  state_t                    state, state_nx;
  logic [CLASS_W-1:0]        sel_q, sel_nx;
  logic [CLASS_W-1:0]        best_cls, best_cls_nx;
  logic signed [SUM_W-1:0]   best_sum, best_sum_nx;
  logic                      err_q, err_nx;
  logic [TMO_W-1:0]          wd, wd_nx;
  logic signed [SUM_W-1:0]   sum_in;

  assign sum_in = $signed(bus.class_sum);

  always_comb begin
    state_nx    = state;
    sel_nx      = sel_q;
    best_cls_nx = best_cls;
    best_sum_nx = best_sum;
    err_nx      = err_q;
    wd_nx       = wd;
    case (state)
      IDLE: if (start) begin
        state_nx    = LAUNCH;
        sel_nx      = '0;
        best_cls_nx = '0;
        best_sum_nx = '0;
        err_nx      = 1'b0;
      end
      LAUNCH: begin
        wd_nx    = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        wd_nx = wd + TMO_W'(1);
        // done has priority over an expiring watchdog in the same cycle
        if (bus.core_done) state_nx = CAPTURE;
        else if (wd == TMO_LAST) begin
          err_nx   = 1'b1;
          state_nx = OUT;
        end
      end
      CAPTURE: begin
        // strict compare: ties keep the lower class index
        if (sel_q == '0 || sum_in > best_sum) begin
          best_sum_nx = sum_in;
          best_cls_nx = sel_q;
        end
        state_nx = RELEASE;
      end
      RELEASE: begin
        if (sel_q == SEL_LAST) state_nx = OUT;
        else begin
          sel_nx   = sel_q + CLASS_W'(1);
          state_nx = LAUNCH;
        end
      end
      OUT: if (bus.pred_valid && bus.pred_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.class_sel = sel_q;

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sel_q          <= '0;
      best_cls       <= '0;
      best_sum       <= '0;
      err_q          <= 1'b0;
      wd             <= '0;
      busy           <= 1'b0;
      bus.core_stop  <= 1'b1;
      bus.core_rst   <= 1'b0;
      bus.pred_valid <= 1'b0;
      bus.pred_class <= '0;
      bus.pred_sum   <= '0;
      bus.pred_err   <= 1'b0;
    end else begin
      state          <= state_nx;
      sel_q          <= sel_nx;
      best_cls       <= best_cls_nx;
      best_sum       <= best_sum_nx;
      err_q          <= err_nx;
      wd             <= wd_nx;
      busy           <= (state_nx != IDLE);
      bus.core_stop  <= (state_nx != LAUNCH);
      bus.core_rst   <= (state_nx == RELEASE) || (state == WAIT && state_nx == OUT);
      bus.pred_valid <= (state_nx == OUT);
      if (state_nx == OUT && state != OUT) begin
        bus.pred_class <= best_cls_nx;
        bus.pred_sum   <= best_sum_nx;
        bus.pred_err   <= err_nx;
      end
    end
  end
endmodule

// File: tb/tb_tm_class_scheduler.sv
// Directed bench: behavioural TM core, protocol monitor and result scoreboard.
module tb_tm_class_scheduler;
  localparam int CLASSES = 4, SUM_W = 12, TIMEOUT = 64, TMO_W = 7, CLASS_W = 2;
  localparam int CORE_T = 20;
  localparam int LAT_OK = 1 + CLASSES * 24;
  localparam int LAT_TMO = 1 + 24 + 1 + TIMEOUT;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, busy;

  tm_class_scheduler_if #(.SUM_W(SUM_W), .CLASS_W(CLASS_W)) bus();

  tm_class_scheduler #(.CLASSES(CLASSES), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {int cls; int sum; bit err;} exp_t;
  exp_t sb[$];

  int sums[CLASSES];
  int hang_cls = -1;
  int vec = 0, miss = 0;
  int stop_cnt = 0, rst_cnt = 0;
  int cnt;
  logic [CLASS_W-1:0] launch_sel;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // core: done CORE_T cycles after launch, held until released; hang_cls never finishes
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= 0;
      bus.core_done <= 1'b0;
      bus.class_sum <= '0;
    end else begin
      if (bus.core_rst) bus.core_done <= 1'b0;
      if (!bus.core_stop) begin
        if (int'(bus.class_sel) != hang_cls) cnt <= CORE_T;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          bus.core_done <= 1'b1;
          bus.class_sum <= SUM_W'(sums[bus.class_sel]);
        end
      end
    end

  always @(negedge clk)
    if (rst_n) begin
      if (!bus.core_stop) begin
        stop_cnt++;
        launch_sel = bus.class_sel;
      end
      if (bus.core_rst) begin
        rst_cnt++;
        chk("sel_const", bus.class_sel, launch_sel);
      end
    end

  task automatic chk_reset();
    chk("rst_core_stop", bus.core_stop, 1);
    chk("rst_core_rst", bus.core_rst, 0);
    chk("rst_class_sel", bus.class_sel, 0);
    chk("rst_pred_valid", bus.pred_valid, 0);
    chk("rst_pred_class", bus.pred_class, 0);
    chk("rst_pred_sum", bus.pred_sum, 0);
    chk("rst_pred_err", bus.pred_err, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic run(input int s0, s1, s2, s3, input int hang, input int e_cls, e_sum,
                     input bit e_err, input int e_lat, input int e_pulses, input int hold);
    exp_t e;
    int cyc;
    sums = '{s0, s1, s2, s3};
    hang_cls = hang;
    stop_cnt = 0;
    rst_cnt = 0;
    sb.push_back('{e_cls, e_sum, e_err});
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end while (!bus.pred_valid && cyc < 2000);
    chk("pred_valid_seen", bus.pred_valid, 1);
    chk("latency", cyc, e_lat);
    chk("core_rst_on_out", bus.core_rst, e_err);
    e = sb.pop_front();
    chk("pred_class", bus.pred_class, e.cls);
    chk("pred_sum", $signed(bus.pred_sum), e.sum);
    chk("pred_err", bus.pred_err, e.err);
    chk("busy_out", busy, 1);
    for (int i = 0; i < hold; i++) begin
      start = (i % 5 == 2);
      @(negedge clk);
      chk("hold_stable", {busy, bus.pred_valid, bus.pred_err, bus.pred_class, bus.pred_sum},
          {1'b1, 1'b1, e.err, CLASS_W'(e.cls), SUM_W'(e.sum)});
    end
    bus.pred_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    bus.pred_ready = 1'b0;
    start = 1'b0;
    chk("pred_valid_drop", bus.pred_valid, 0);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    chk("no_restart", busy, 0);
    chk("stop_pulses", stop_cnt, e_pulses);
    chk("rst_pulses", rst_cnt, e_pulses);
  endtask

  initial begin
    int cyc;
    bus.pred_ready = 1'b0;
    sums = '{0, 0, 0, 0};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;

    run(3, -5, 7, 7, -1, 2, 7, 1'b0, LAT_OK, CLASSES, 0);
    run(-8, -2, -9, -2, -1, 1, -2, 1'b0, LAT_OK, CLASSES, 0);
    run(1, 9, 4, 9, -1, 1, 9, 1'b0, LAT_OK, CLASSES, 50);
    run(5, 11, 2, 3, 1, 0, 5, 1'b1, LAT_TMO, 2, 3);

    // async reset in the middle of class 2's wait
    sums = '{4, 6, 8, 1};
    hang_cls = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (bus.class_sel != 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) @(negedge clk);
    chk("mid_wait_sel", bus.class_sel, 2);
    chk("mid_wait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    run(2, 8, -3, 8, -1, 1, 8, 1'b0, LAT_OK, CLASSES, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
